// File: rtl/dlsc_axi_writer_frame.sv
// Frame-level sequencer for dlsc_axi_writer: turns one 2D frame descriptor into
// one writer command per row and reports completion once every row is acknowledged.
module dlsc_axi_writer_frame #(
    parameter int ADDR = 32,
    parameter int BLEN = 12,
    parameter int ROWS = 12,
    parameter int OUTS = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            frm_ready,
    input  logic            frm_valid,
    input  logic [ADDR-1:0] frm_addr,
    input  logic [BLEN-1:0] frm_bytes,
    input  logic [ADDR-1:0] frm_stride,
    input  logic [ROWS-1:0] frm_rows,
    output logic            frm_busy,
    output logic            frm_done,
    output logic            frm_error,
    input  logic            cmd_ready,
    output logic            cmd_valid,
    output logic [ADDR-1:0] cmd_addr,
    output logic [BLEN-1:0] cmd_bytes,
    input  logic            cmd_done,
    input  logic            axi_busy,
    input  logic            axi_error
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_ERROR = 2'd3
    } state_t;

    localparam logic [OUTS-1:0] OUT_ONE = OUTS'(1);
    localparam logic [OUTS-1:0] OUT_MAX = '1;
    localparam logic [ROWS-1:0] ROW_ONE = ROWS'(1);

    state_t          state;
    logic [ADDR-1:0] row_addr;
    logic [ADDR-1:0] stride;
    logic [BLEN-1:0] bytes_q;
    logic [ROWS-1:0] rows_left;
    logic [ROWS-1:0] done_left;
    logic [ROWS-1:0] done_left_nxt;
    logic [OUTS-1:0] outstanding;
    logic [OUTS-1:0] outstanding_nxt;
    logic            hs;
    logic            done_in;
    logic            can_issue;

    // cmd_valid/cmd_ready: a command transfers on any edge where both are high;
    // once raised, cmd_valid and its addr/bytes hold until that edge (or an AXI error).
    assign frm_ready = (state == ST_IDLE);
    assign frm_busy  = (state != ST_IDLE) || axi_busy;
    assign hs        = cmd_valid && cmd_ready && (state == ST_ISSUE);
    assign done_in   = cmd_done && (state != ST_IDLE);
    assign can_issue = !cmd_valid && (rows_left != '0) && (outstanding != OUT_MAX);

    always_comb begin
        outstanding_nxt = outstanding;
        if (hs && !done_in) begin
            outstanding_nxt = outstanding + OUT_ONE;
        end else if (!hs && done_in) begin
            outstanding_nxt = outstanding - OUT_ONE;
        end
        done_left_nxt = done_in ? (done_left - ROW_ONE) : done_left;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            row_addr    <= '0;
            stride      <= '0;
            bytes_q     <= '0;
            rows_left   <= '0;
            done_left   <= '0;
            outstanding <= '0;
            cmd_valid   <= 1'b0;
            cmd_addr    <= '0;
            cmd_bytes   <= '0;
            frm_done    <= 1'b0;
            frm_error   <= 1'b0;
        end else begin
            frm_done    <= 1'b0;
            outstanding <= outstanding_nxt;
            done_left   <= done_left_nxt;
            case (state)
                ST_IDLE: begin
                    if (axi_error) begin
                        state     <= ST_ERROR;
                        frm_error <= 1'b1;
                    end else if (frm_valid) begin
                        row_addr  <= frm_addr;
                        stride    <= frm_stride;
                        bytes_q   <= frm_bytes;
                        rows_left <= frm_rows;
                        done_left <= frm_rows;
                        if (frm_rows == '0) begin
                            frm_done <= 1'b1;
                        end else begin
                            state <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (axi_error) begin
                        state     <= ST_ERROR;
                        frm_error <= 1'b1;
                        cmd_valid <= 1'b0;
                    end else if (hs) begin
                        cmd_valid <= 1'b0;
                        row_addr  <= row_addr + stride;
                        rows_left <= rows_left - ROW_ONE;
                        if (rows_left == ROW_ONE) begin
                            state <= ST_DRAIN;
                        end
                    end else if (can_issue) begin
                        cmd_valid <= 1'b1;
                        cmd_addr  <= row_addr;
                        cmd_bytes <= bytes_q;
                    end
                end
                ST_DRAIN: begin
                    if (axi_error) begin
                        state     <= ST_ERROR;
                        frm_error <= 1'b1;
                    end else if (done_left_nxt == '0) begin
                        frm_done <= 1'b1;
                        state    <= ST_IDLE;
                    end
                end
                ST_ERROR: begin
                    // The writer's error only clears on reset, so neither do we.
                    cmd_valid <= 1'b0;
                    frm_error <= 1'b1;
                end
                default: begin
                    state <= ST_ERROR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dlsc_axi_writer_frame.sv
// Directed bench for dlsc_axi_writer_frame with a small writer model that answers
// commands with delayed cmd_done pulses and checks issued addresses in order.
module tb_dlsc_axi_writer_frame;

    localparam int ADDR = 32;
    localparam int BLEN = 12;
    localparam int ROWS = 12;
    localparam int OUTS = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            frm_ready;
    logic            frm_valid;
    logic [ADDR-1:0] frm_addr;
    logic [BLEN-1:0] frm_bytes;
    logic [ADDR-1:0] frm_stride;
    logic [ROWS-1:0] frm_rows;
    logic            frm_busy;
    logic            frm_done;
    logic            frm_error;
    logic            cmd_ready;
    logic            cmd_valid;
    logic [ADDR-1:0] cmd_addr;
    logic [BLEN-1:0] cmd_bytes;
    logic            cmd_done;
    logic            axi_busy;
    logic            axi_error;

    dlsc_axi_writer_frame #(
        .ADDR(ADDR), .BLEN(BLEN), .ROWS(ROWS), .OUTS(OUTS)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .frm_ready(frm_ready), .frm_valid(frm_valid), .frm_addr(frm_addr),
        .frm_bytes(frm_bytes), .frm_stride(frm_stride), .frm_rows(frm_rows),
        .frm_busy(frm_busy), .frm_done(frm_done), .frm_error(frm_error),
        .cmd_ready(cmd_ready), .cmd_valid(cmd_valid), .cmd_addr(cmd_addr),
        .cmd_bytes(cmd_bytes), .cmd_done(cmd_done), .axi_busy(axi_busy),
        .axi_error(axi_error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [31:0] exp_q[$];
    int          due_q[$];
    logic [31:0] exp_bytes = 0;
    int          frame_rows = 0;
    int          done_base = 0;
    int          cyc = 0;
    int          hs_cnt = 0;
    int          done_cnt = 0;
    int          valid_cnt = 0;
    int          frmdone_cnt = 0;
    int          exp_fd = 0;
    int          lat_min = 0;
    int          lat_max = 0;
    int          release_req = 0;
    int          release_used = 0;
    logic        done_en = 1'b1;
    logic        rand_ready = 1'b0;

    // Writer model: checks commands at the negedge, drives cmd_ready/cmd_done after posedge.
    initial begin : writer_model
        logic        pv, pr, pd;
        logic [31:0] pa, pb, ea;
        pv = 0; pr = 0; pd = 0; pa = 0; pb = 0;
        cmd_ready = 1'b0;
        cmd_done  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                due_q.delete();
                pv = 0; pd = 0;
            end else begin
                if (cmd_valid) valid_cnt++;
                if (pv && !pr && cmd_valid) begin
                    check_eq("stall_addr", cmd_addr, pa);
                    check_eq("stall_bytes", 32'(cmd_bytes), pb);
                end
                if (cmd_valid && cmd_ready) begin
                    hs_cnt++;
                    if (exp_q.size() == 0) begin
                        check_eq("cmd_overrun", 32'(exp_q.size()), 32'd1);
                    end else begin
                        ea = exp_q.pop_front();
                        check_eq("cmd_addr", cmd_addr, ea);
                        check_eq("cmd_bytes", 32'(cmd_bytes), exp_bytes);
                    end
                    due_q.push_back(cyc + 1 + int'($urandom_range(lat_min, lat_max)));
                end
                if (cmd_done) done_cnt++;
                if (frm_done) begin
                    frmdone_cnt++;
                    check_eq("frm_done_width", 32'(pd), 32'd0);
                    check_eq("dones_at_frm_done", 32'(done_cnt - done_base), 32'(frame_rows));
                end
                pv = cmd_valid; pr = cmd_ready; pa = cmd_addr; pb = 32'(cmd_bytes); pd = frm_done;
            end
            @(posedge clk);
            #1;
            cyc++;
            cmd_done = 1'b0;
            if (rst_n && due_q.size() > 0 && due_q[0] <= cyc &&
                (done_en || release_used < release_req)) begin
                void'(due_q.pop_front());
                cmd_done = 1'b1;
                if (!done_en) release_used++;
            end
            cmd_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        axi_error = 1'b0;
        frm_valid = 1'b0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check_eq("rst_cmd_addr", cmd_addr, 32'd0);
        check_eq("rst_cmd_bytes", 32'(cmd_bytes), 32'd0);
        check_eq("rst_frm_done", 32'(frm_done), 32'd0);
        check_eq("rst_frm_error", 32'(frm_error), 32'd0);
        check_eq("rst_frm_ready", 32'(frm_ready), 32'd1);
        check_eq("rst_frm_busy", 32'(frm_busy), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic send_frame(input logic [31:0] a, input logic [11:0] b,
                              input logic [31:0] s, input int rows);
        logic [31:0] x;
        int t;
        x = a;
        exp_bytes = 32'(b);
        frame_rows = rows;
        done_base = done_cnt;
        for (int i = 0; i < rows; i++) begin
            exp_q.push_back(x);
            x = x + s;
        end
        frm_addr = a; frm_bytes = b; frm_stride = s; frm_rows = ROWS'(rows);
        frm_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!frm_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check_eq("frm_accept", 32'(frm_ready), 32'd1);
        @(posedge clk);
        #1;
        frm_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int t;
        t = 0;
        while (frmdone_cnt < exp_fd && t < budget) begin
            step(1);
            t++;
        end
        check_eq("frm_done_seen", 32'(frmdone_cnt), 32'(exp_fd));
    endtask

    initial begin : main
        int hs0, dn0, vc0, t, r;
        logic [31:0] a, s;
        frm_valid = 0; frm_addr = 0; frm_bytes = 0; frm_stride = 0; frm_rows = 0;
        axi_busy = 0; axi_error = 0;
        do_reset();

        // Basic 4-row frame, done 20 cycles after each issue
        lat_min = 19; lat_max = 19;
        hs0 = hs_cnt;
        send_frame(32'h1000, 12'd64, 32'h400, 4);
        @(negedge clk);
        check_eq("t1_busy", 32'(frm_busy), 32'd1);
        exp_fd++;
        wait_done(400);
        check_eq("t1_cmds", 32'(hs_cnt - hs0), 32'd4);
        check_eq("t1_dones", 32'(done_cnt - done_base), 32'd4);
        step(3);
        check_eq("t1_single_done", 32'(frmdone_cnt), 32'(exp_fd));
        check_eq("t1_idle_ready", 32'(frm_ready), 32'd1);
        check_eq("t1_idle_busy", 32'(frm_busy), 32'd0);
        axi_busy = 1'b1;
        @(negedge clk);
        check_eq("axi_busy_pass", 32'(frm_busy), 32'd1);
        step(1);
        axi_busy = 1'b0;

        // Outstanding limit of 3 with dones withheld
        lat_min = 0; lat_max = 0; done_en = 1'b0;
        hs0 = hs_cnt;
        send_frame(32'h2000, 12'd16, 32'h10, 6);
        step(20);
        check_eq("t2_limit", 32'(hs_cnt - hs0), 32'd3);
        release_req++;
        step(10);
        check_eq("t2_after_release", 32'(hs_cnt - hs0), 32'd4);
        check_eq("t2_no_early_done", 32'(frmdone_cnt), 32'(exp_fd));
        done_en = 1'b1;
        exp_fd++;
        wait_done(200);
        check_eq("t2_cmds", 32'(hs_cnt - hs0), 32'd6);
        check_eq("t2_dones", 32'(done_cnt - done_base), 32'd6);

        // Zero-row frame
        vc0 = valid_cnt;
        send_frame(32'h5000, 12'd4, 32'h10, 0);
        @(negedge clk);
        check_eq("t3_done_hi", 32'(frm_done), 32'd1);
        @(negedge clk);
        check_eq("t3_done_lo", 32'(frm_done), 32'd0);
        check_eq("t3_no_cmd", 32'(valid_cnt - vc0), 32'd0);
        exp_fd++;
        check_eq("t3_done_cnt", 32'(frmdone_cnt), 32'(exp_fd));
        step(1);

        // Address wrap
        lat_min = 2; lat_max = 2;
        hs0 = hs_cnt;
        send_frame(32'hFFFF_FF00, 12'd8, 32'h100, 2);
        exp_fd++;
        wait_done(200);
        check_eq("t4_cmds", 32'(hs_cnt - hs0), 32'd2);
        check_eq("t4_exp_empty", 32'(exp_q.size()), 32'd0);

        // AXI error after row 2 of 5, asserted while the third command is offered
        done_en = 1'b0; lat_min = 0; lat_max = 0;
        hs0 = hs_cnt;
        send_frame(32'h3000, 12'd32, 32'h40, 5);
        t = 0;
        while (hs_cnt - hs0 < 2 && t < 50) begin
            step(1);
            t++;
        end
        check_eq("t5_two_rows", 32'(hs_cnt - hs0), 32'd2);
        step(1);
        axi_error = 1'b1;
        @(negedge clk);
        check_eq("t5_valid_pre", 32'(cmd_valid), 32'd1);
        @(negedge clk);
        check_eq("t5_valid_drop", 32'(cmd_valid), 32'd0);
        check_eq("t5_error", 32'(frm_error), 32'd1);
        check_eq("t5_not_ready", 32'(frm_ready), 32'd0);
        check_eq("t5_busy", 32'(frm_busy), 32'd1);
        done_en = 1'b1;
        vc0 = valid_cnt;
        step(15);
        check_eq("t5_error_held", 32'(frm_error), 32'd1);
        check_eq("t5_no_valid", 32'(valid_cnt - vc0), 32'd0);
        check_eq("t5_no_done", 32'(frmdone_cnt), 32'(exp_fd));
        do_reset();

        // AXI error while idle
        step(1);
        axi_error = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_eq("idle_err_flag", 32'(frm_error), 32'd1);
        check_eq("idle_err_ready", 32'(frm_ready), 32'd0);
        do_reset();

        // Random cmd_ready and short done latency over 100 frames
        rand_ready = 1'b1; lat_min = 0; lat_max = 3; done_en = 1'b1;
        for (int f = 0; f < 100; f++) begin
            r = int'($urandom_range(1, 6));
            a = $urandom;
            s = 32'($urandom_range(0, 255)) << 4;
            hs0 = hs_cnt;
            dn0 = done_cnt;
            send_frame(a, 12'($urandom_range(1, 4095)), s, r);
            exp_fd++;
            wait_done(300);
            check_eq("t6_cmds", 32'(hs_cnt - hs0), 32'(r));
            check_eq("t6_dones", 32'(done_cnt - dn0), 32'(r));
        end
        check_eq("final_exp_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
